ball_collision_manager: RTL and testbench
=========================================

# ball_collision_manager

Parametrised, frame-based successor to the per-ball collision AND-gate logic. Takes pixel-level draw requests from the player, the rope and `NUM_BALLS` ball objects, and accumulates overlaps over a full video frame. At each frame boundary it emits clean one-cycle collision pulses to the game controller. Rope pops are limited to one ball per frame, and an invulnerability window masks repeated player hits.

## Interface
- `NUM_BALLS`, default 15: number of ball objects (1 huge + 2 big + 4 medium + 8 small).
- `INVULN_FRAMES`, default 60: frames during which player hits are masked after a reported player hit; 0 disables masking.
- `clk` in 1: system clock. One clock domain.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse marking the first pixel of a new frame.
- `playerRequest` in 1: player pixel is drawn this cycle.
- `ropeRequest` in 1: rope pixel is drawn this cycle.
- `ballRequest` in `NUM_BALLS`: per-ball pixel-drawn flags.
- `col_rope_ball` out `NUM_BALLS`: one-cycle pulse, at most one bit set; that ball was popped.
- `col_player_ball` out `NUM_BALLS`: one-cycle pulse; those balls hit the player.
- `col_rope_any` out 1: OR of `col_rope_ball`; the rope must retract.
- `col_player_any` out 1: OR of `col_player_ball`.
- `playerInvulnerable` out 1: level; high while player hits are masked.

## Operation
- Per cycle, raw overlap is `ropeRaw[i] = ropeRequest & ballRequest[i]` and `playerRaw[i] = playerRequest & ballRequest[i]`.
- Two sticky accumulators, `ropeAcc` and `playerAcc` (each `NUM_BALLS` wide), OR in the raw overlaps every cycle.
- On a `startOfFrame` cycle:
  - Accumulators are committed to the output stage.
  - Accumulators are reloaded with that cycle's raw overlaps, not cleared to 0. Requests in the SOF cycle belong to the new frame.
- Commit, rope:
  - `col_rope_ball` = lowest-index set bit of `ropeAcc` (priority encode to one-hot).
  - Lower indices are the larger balls, so a larger ball wins.
- Commit, player:
  - `col_player_ball` = `playerAcc & ~col_rope_ball_next`. A ball popped this frame cannot also hit the player.
  - The whole player vector is forced to 0 when the state is INVULN.
- Player state machine (two states):
  - ARMED → INVULN on a commit with a nonzero masked player vector; load counter with `INVULN_FRAMES`.
  - INVULN: the counter decrements on each `startOfFrame`. INVULN → ARMED when a commit sees counter == 1. The mask applies on that final commit, and the counter goes to 0.
  - With `INVULN_FRAMES` = 0, the state never leaves ARMED.
- `playerInvulnerable` = (state == INVULN).
- Counter width is `$clog2(INVULN_FRAMES+1)`, minimum 1 bit. It never wraps below 0.
- Without any `startOfFrame`, accumulators stay sticky indefinitely and no pulses are emitted.

## Timing
- Reset (async assert, sync-safe deassert):
  - All outputs 0.
  - Accumulators 0, counter 0, state ARMED.
- Latency: a commit at SOF cycle T drives pulses high in cycle T+1 only. All outputs are registered.
- `playerInvulnerable` rises in T+1, the same cycle as the triggering `col_player_any` pulse.
- `playerInvulnerable` falls in the cycle after the commit that ends INVULN.
- Back-to-back `startOfFrame` pulses are legal. Each one commits and decrements independently; pulses may appear on consecutive cycles.
- Reset mid-frame discards partial accumulations and any pending invulnerability.
- Simultaneous rope and player overlap on the same ball in one frame: only the rope pulse is reported.

## Structure
- Package `collision_pkg`:
  - `NUM_BALLS` default.
  - Ball index constants (`HUGE_IDX`=0, `BIG_BASE`=1, `MED_BASE`=3, `SMALL_BASE`=7).
  - `typedef enum logic {ARMED, INVULN} player_col_state_t`.
- One sub-module, `invuln_timer`:
  - Holds the state machine and frame counter.
  - Inputs: `clk`, `resetN`, `startOfFrame`, `hit`.
  - Output: `active`.
- The priority encoder and accumulators stay in the top module.

## Test plan
- Rope overlaps ball 3 for 5 cycles mid-frame, then SOF at cycle T → `col_rope_ball` = 1<<3 and `col_rope_any` = 1 in T+1 only; 0 in T+2.
- Rope overlaps balls 5 and 2 in the same frame → only bit 2 pulses at commit.
- Player overlaps ball 7 in frame 0 with `INVULN_FRAMES`=3:
  - Commit → `col_player_ball` = 1<<7 and `playerInvulnerable` rises.
  - Repeat overlap in the next 3 frames → no pulse.
  - 4th frame overlap → pulses again.
- Rope and player both overlap ball 0 in one frame → `col_rope_ball` = 1, `col_player_ball` = 0, no invulnerability entered.
- Overlap on ball 4 only in the SOF cycle → not reported at that commit; reported at the next SOF.
- Assert `resetN` low mid-frame with `ropeAcc` nonzero and INVULN active → all outputs 0 immediately; next SOF reports nothing.

Source files
------------

// File: rtl/ball_collision_manager_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Shared constants and types for the frame-based ball collision manager.
//   NUM_BALLS_DEFAULT : default number of ball objects (1 huge, 2 big,
//                       4 medium, 8 small)
//   *_IDX / *_BASE    : first index of each ball size class; lower index means
//                       a larger ball
//   player_col_state_t: player hit-masking state
// -----------------------------------------------------------------------------
package collision_pkg;

    localparam int NUM_BALLS_DEFAULT = 15;

    localparam int HUGE_IDX   = 0;
    localparam int BIG_BASE   = 1;
    localparam int MED_BASE   = 3;
    localparam int SMALL_BASE = 7;

    typedef enum logic {
        ARMED  = 1'b0,
        INVULN = 1'b1
    } player_col_state_t;

endpackage

// File: rtl/ball_collision_manager_invuln_timer.sv
// -----------------------------------------------------------------------------
// invuln_timer
// Player invulnerability state machine with a frame counter. After a reported
// player hit, further player hits are masked for INVULN_FRAMES commits.
//   clk          : system clock
//   resetN       : asynchronous active-low reset
//   startOfFrame : one-cycle frame-boundary pulse (commit cycle)
//   hit          : the commit in this cycle carries a nonzero player vector
//   active       : registered, high while player hits are masked
// -----------------------------------------------------------------------------
module invuln_timer
    import collision_pkg::*;
#(
    parameter int INVULN_FRAMES = 60
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic hit,
    output logic active
);

    localparam int CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(INVULN_FRAMES);

    player_col_state_t r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_active;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order in the block.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= ARMED;
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (startOfFrame) begin
            case (r_state)
                ARMED: begin
                    // A zero window means masking is disabled entirely.
                    if (hit && (INVULN_FRAMES != 0)) begin
                        r_state  <= INVULN;
                        r_count  <= LOAD_VAL;
                        r_active <= 1'b1;
                    end
                end
                INVULN: begin
                    // This commit is still masked; <= 1 keeps the counter
                    // from ever wrapping below zero.
                    if (r_count <= CNT_W'(1)) begin
                        r_state  <= ARMED;
                        r_count  <= '0;
                        r_active <= 1'b0;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= ARMED;
                    r_count  <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign active = r_active;

endmodule

// File: rtl/ball_collision_manager.sv
// -----------------------------------------------------------------------------
// ball_collision_manager
// Accumulates pixel-level overlaps between the player, the rope and each ball
// over a video frame, and at every frame boundary emits one-cycle collision
// pulses. At most one ball (the largest) is popped by the rope per frame, and
// player hits are masked for a window of frames after a reported hit.
//   clk, resetN         : clock, asynchronous active-low reset
//   startOfFrame        : one-cycle pulse on the first pixel of a frame
//   playerRequest       : player pixel drawn this cycle
//   ropeRequest         : rope pixel drawn this cycle
//   ballRequest         : per-ball pixel drawn flags
//   col_rope_ball       : one-hot pulse, ball popped by the rope
//   col_player_ball     : pulse, balls that hit the player
//   col_rope_any        : OR of col_rope_ball (rope must retract)
//   col_player_any      : OR of col_player_ball
//   playerInvulnerable  : level, high while player hits are masked
// -----------------------------------------------------------------------------
module ball_collision_manager
    import collision_pkg::*;
#(
    parameter int NUM_BALLS     = NUM_BALLS_DEFAULT,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 playerRequest,
    input  logic                 ropeRequest,
    input  logic [NUM_BALLS-1:0] ballRequest,
    output logic [NUM_BALLS-1:0] col_rope_ball,
    output logic [NUM_BALLS-1:0] col_player_ball,
    output logic                 col_rope_any,
    output logic                 col_player_any,
    output logic                 playerInvulnerable
);

    logic [NUM_BALLS-1:0] w_rope_raw;
    logic [NUM_BALLS-1:0] w_player_raw;
    logic [NUM_BALLS-1:0] r_rope_acc;
    logic [NUM_BALLS-1:0] r_player_acc;
    logic [NUM_BALLS-1:0] w_rope_onehot;
    logic [NUM_BALLS-1:0] w_player_next;
    logic                 w_invuln;

    assign w_rope_raw   = {NUM_BALLS{ropeRequest}}   & ballRequest;
    assign w_player_raw = {NUM_BALLS{playerRequest}} & ballRequest;

    // Lowest set index wins: lower indices are the larger balls.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        logic found;
        w_rope_onehot = '0;
        found         = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (r_rope_acc[i] && !found) begin
                w_rope_onehot[i] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    // A ball popped this frame cannot also hit the player.
    assign w_player_next = w_invuln ? '0 : (r_player_acc & ~w_rope_onehot);

    // Requests in the SOF cycle belong to the new frame, so the accumulators
    // reload with this cycle's overlap instead of clearing.
    // NOTE: the accumulators are plain flops, so they take the async reset;
    // a mid-frame reset must discard any partial frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rope_acc   <= '0;
            r_player_acc <= '0;
        end else if (startOfFrame) begin
            r_rope_acc   <= w_rope_raw;
            r_player_acc <= w_player_raw;
        end else begin
            r_rope_acc   <= r_rope_acc   | w_rope_raw;
            r_player_acc <= r_player_acc | w_player_raw;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            col_rope_ball   <= '0;
            col_player_ball <= '0;
            col_rope_any    <= 1'b0;
            col_player_any  <= 1'b0;
        end else if (startOfFrame) begin
            col_rope_ball   <= w_rope_onehot;
            col_player_ball <= w_player_next;
            col_rope_any    <= |w_rope_onehot;
            col_player_any  <= |w_player_next;
        end else begin
            col_rope_ball   <= '0;
            col_player_ball <= '0;
            col_rope_any    <= 1'b0;
            col_player_any  <= 1'b0;
        end
    end

    invuln_timer #(
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_invuln_timer (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .hit          (|w_player_next),
        .active       (w_invuln)
    );

    assign playerInvulnerable = w_invuln;

endmodule

// File: tb/tb_ball_collision_manager.sv
// -----------------------------------------------------------------------------
// tb_ball_collision_manager
// Self-checking bench: a behavioural frame model predicts the outputs for
// every driven cycle, pushes them to a queue, and pops/compares them once the
// DUT has clocked that cycle. Directed checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_ball_collision_manager;
    import collision_pkg::*;

    localparam int NB   = 15;
    localparam int INVF = 3;

    logic          clk = 1'b0;
    logic          resetN;
    logic          startOfFrame;
    logic          playerRequest;
    logic          ropeRequest;
    logic [NB-1:0] ballRequest;
    logic [NB-1:0] col_rope_ball;
    logic [NB-1:0] col_player_ball;
    logic          col_rope_any;
    logic          col_player_any;
    logic          playerInvulnerable;

    always #5 clk = ~clk;

    ball_collision_manager #(
        .NUM_BALLS     (NB),
        .INVULN_FRAMES (INVF)
    ) dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .playerRequest      (playerRequest),
        .ropeRequest        (ropeRequest),
        .ballRequest        (ballRequest),
        .col_rope_ball      (col_rope_ball),
        .col_player_ball    (col_player_ball),
        .col_rope_any       (col_rope_any),
        .col_player_any     (col_player_any),
        .playerInvulnerable (playerInvulnerable)
    );

    typedef struct packed {
        logic [NB-1:0] rope;
        logic [NB-1:0] player;
        logic          rany;
        logic          pany;
        logic          inv;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Frame model state
    logic [NB-1:0] m_rope_acc;
    logic [NB-1:0] m_player_acc;
    bit            m_inv;
    int            m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] largest_ball(input logic [NB-1:0] v);
        logic [NB-1:0] one;
        logic [NB-1:0] r;
        one = 1;
        r   = '0;
        for (int i = NB - 1; i >= 0; i--)
            if (v[i]) r = one << i;
        return r;
    endfunction

    function automatic logic [NB-1:0] bit_of(input int idx);
        logic [NB-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    // Drive one cycle, predict its outputs, clock it, compare.
    task automatic step(input bit s, input bit p, input bit r, input logic [NB-1:0] b);
        exp_t          e;
        exp_t          got;
        logic [NB-1:0] rr;
        logic [NB-1:0] pr;
        startOfFrame  = s;
        playerRequest = p;
        ropeRequest   = r;
        ballRequest   = b;
        rr = r ? b : '0;
        pr = p ? b : '0;
        e  = '0;
        if (s) begin
            e.rope   = largest_ball(m_rope_acc);
            e.player = m_inv ? '0 : (m_player_acc & ~e.rope);
            e.rany   = |e.rope;
            e.pany   = |e.player;
            if (!m_inv) begin
                if (e.player != '0 && INVF > 0) begin
                    m_inv = 1'b1;
                    m_cnt = INVF;
                end
            end else if (m_cnt == 1) begin
                m_inv = 1'b0;
                m_cnt = 0;
            end else begin
                m_cnt--;
            end
            m_rope_acc   = rr;
            m_player_acc = pr;
        end else begin
            m_rope_acc   = m_rope_acc | rr;
            m_player_acc = m_player_acc | pr;
        end
        e.inv = m_inv;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check("sb_rope_ball",   32'(col_rope_ball),      32'(got.rope));
            check("sb_player_ball", 32'(col_player_ball),    32'(got.player));
            check("sb_rope_any",    32'(col_rope_any),       32'(got.rany));
            check("sb_player_any",  32'(col_player_any),     32'(got.pany));
            check("sb_invuln",      32'(playerInvulnerable), 32'(got.inv));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        startOfFrame  = 1'b0;
        playerRequest = 1'b0;
        ropeRequest   = 1'b0;
        ballRequest   = '0;
        resetN        = 1'b0;
        #2;
        check("rst_rope_ball",   32'(col_rope_ball),      32'd0);
        check("rst_player_ball", 32'(col_player_ball),    32'd0);
        check("rst_rope_any",    32'(col_rope_any),       32'd0);
        check("rst_player_any",  32'(col_player_any),     32'd0);
        check("rst_invuln",      32'(playerInvulnerable), 32'd0);
        m_rope_acc   = '0;
        m_player_acc = '0;
        m_inv        = 1'b0;
        m_cnt        = 0;
        sb_q.delete();
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN        = 1'b1;
        startOfFrame  = 1'b0;
        playerRequest = 1'b0;
        ropeRequest   = 1'b0;
        ballRequest   = '0;
        #1;
        do_reset();

        // Rope on ball 3 for 5 cycles mid-frame; pulse only in T+1.
        step(1'b1, 1'b0, 1'b0, '0);
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, bit_of(MED_BASE));
        idle(2);
        step(1'b1, 1'b0, 1'b0, '0);
        check("rope3_pulse", 32'(col_rope_ball), 32'h8);
        check("rope3_any",   32'(col_rope_any),  32'd1);
        idle(1);
        check("rope3_gone",  32'(col_rope_ball), 32'd0);
        check("rope3_any0",  32'(col_rope_any),  32'd0);

        // Balls 5 and 2 in one frame: only the larger (2) pops.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, bit_of(5));
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, bit_of(2));
        step(1'b0, 1'b0, 1'b1, bit_of(5) | bit_of(2));
        step(1'b1, 1'b0, 1'b0, '0);
        check("rope52_pulse", 32'(col_rope_ball), 32'h4);

        // Rope and player on ball 0: rope only, no invulnerability.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, bit_of(HUGE_IDX));
        step(1'b1, 1'b0, 1'b0, '0);
        check("both0_rope",   32'(col_rope_ball),      32'h1);
        check("both0_player", 32'(col_player_ball),    32'd0);
        check("both0_inv",    32'(playerInvulnerable), 32'd0);

        // Overlap only in the SOF cycle belongs to the next frame.
        step(1'b1, 1'b0, 1'b1, bit_of(4));
        check("sof4_now",  32'(col_rope_ball), 32'd0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, '0);
        check("sof4_next", 32'(col_rope_ball), 32'h10);

        // Back-to-back SOF pulses commit independently.
        step(1'b1, 1'b0, 1'b1, bit_of(9));
        step(1'b1, 1'b0, 1'b0, '0);
        check("b2b_rope", 32'(col_rope_ball), 32'h200);
        idle(2);

        // Player on ball 7 with a 3-frame invulnerability window.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, bit_of(SMALL_BASE));
        step(1'b1, 1'b0, 1'b0, '0);
        check("p7_pulse", 32'(col_player_ball),    32'h80);
        check("p7_any",   32'(col_player_any),     32'd1);
        check("p7_inv",   32'(playerInvulnerable), 32'd1);
        for (int f = 1; f <= 3; f++) begin
            for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, bit_of(SMALL_BASE));
            step(1'b1, 1'b0, 1'b0, '0);
            check("p7_masked",   32'(col_player_ball),    32'd0);
            check("p7_inv_hold", 32'(playerInvulnerable), (f < 3) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, bit_of(SMALL_BASE));
        step(1'b1, 1'b0, 1'b0, '0);
        check("p7_again",     32'(col_player_ball),    32'h80);
        check("p7_again_inv", 32'(playerInvulnerable), 32'd1);

        // Reset mid-frame with rope overlap pending and INVULN active.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, bit_of(BIG_BASE));
        check("pre_rst_inv", 32'(playerInvulnerable), 32'd1);
        do_reset();
        idle(2);
        step(1'b1, 1'b0, 1'b0, '0);
        check("post_rst_rope",   32'(col_rope_ball),   32'd0);
        check("post_rst_player", 32'(col_player_ball), 32'd0);

        // Short randomised stretch, checked against the model only.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), NB'($urandom) & NB'($urandom));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
